// File: rtl/gt_link_supervisor.sv
// Bring-up / recovery sequencer for one Ethernet GT channel and its GMII bridge.
// Drives the wrapper soft_reset, retries bounded attempts, latches FAULT when retries run out.
module gt_link_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 500000,
  parameter int DONE_TIMEOUT  = 1000000,
  parameter int AN_TIMEOUT    = 5000000,
  parameter int MAX_RETRY     = 4,
  parameter int BUFERR_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
  input  logic        an_disable,
  input  logic        cpll_locked,
  input  logic        txrx_resetdone,
  input  logic [2:0]  rxbufstatus,
  input  logic [1:0]  txbufstatus,
  input  logic        an_done,
  output logic        soft_reset,
  output logic        link_up,
  output logic        fault,
  output logic [2:0]  state,
  output logic [3:0]  retry_cnt,
  output logic [7:0]  relink_cnt,
  output logic [15:0] buferr_cnt
);

  typedef enum logic [2:0] {
    RESET_PULSE = 3'd0, WAIT_LOCK = 3'd1, WAIT_DONE = 3'd2,
    WAIT_AN     = 3'd3, LINK_UP   = 3'd4, FAULT     = 3'd5
  } st_t;

  // Only the over/underflow bits carry meaning; the rest of the status buses are ignored.
  logic unused_bufstatus;
  assign unused_bufstatus = &{1'b0, rxbufstatus[1:0], txbufstatus[0]};

  logic [4:0] sync1, sync2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {an_done, txbufstatus[1], rxbufstatus[2], txrx_resetdone, cpll_locked};
      sync2 <= sync1;
    end
  end

  logic lock_s, done_s, an_s, err_s;
  assign lock_s = sync2[0];
  assign done_s = sync2[1];
  assign err_s  = sync2[2] | sync2[3];
  assign an_s   = sync2[4];

  st_t         st_q, st_n;
  logic [23:0] tmr_q, tmr_n;
  logic [3:0]  retry_q, retry_n;
  logic [7:0]  relink_q, relink_n;
  logic [7:0]  run_q, run_n;
  logic [15:0] buferr_q;
  logic        err_d;
  logic        fail, relink;

  always_comb begin
    st_n     = st_q;
    tmr_n    = (tmr_q == 24'd0) ? 24'd0 : tmr_q - 24'd1;
    retry_n  = retry_q;
    relink_n = relink_q;
    fail     = 1'b0;
    relink   = 1'b0;
    run_n    = 8'd0;
    if (st_q == LINK_UP && err_s)
      run_n = (run_q == 8'hFF) ? run_q : run_q + 8'd1;

    case (st_q)
      RESET_PULSE: if (tmr_q == 24'd0) st_n = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_s)                st_n = WAIT_DONE;
        else if (tmr_q == 24'd0)   fail = 1'b1;
      end
      WAIT_DONE: begin
        if (!lock_s)               fail = 1'b1;
        else if (done_s)           st_n = an_disable ? LINK_UP : WAIT_AN;
        else if (tmr_q == 24'd0)   fail = 1'b1;
      end
      WAIT_AN: begin
        if (!lock_s || !done_s)    fail = 1'b1;
        else if (an_s)             st_n = LINK_UP;
        else if (tmr_q == 24'd0)   fail = 1'b1;
      end
      LINK_UP: begin
        if (!lock_s || !done_s || (!an_disable && !an_s) ||
            run_n == 8'(BUFERR_CYCLES))
          relink = 1'b1;
      end
      FAULT:   st_n = FAULT;
      default: st_n = RESET_PULSE;
    endcase

    if (fail) begin
      if (retry_q + 4'd1 == 4'(MAX_RETRY)) begin
        st_n    = FAULT;
        retry_n = 4'(MAX_RETRY);
      end else begin
        st_n    = RESET_PULSE;
        retry_n = retry_q + 4'd1;
      end
    end
    if (relink) begin
      st_n     = RESET_PULSE;
      relink_n = (relink_q == 8'hFF) ? relink_q : relink_q + 8'd1;
    end
    if (st_n == LINK_UP && st_q != LINK_UP) retry_n = 4'd0;
    // restart wins over whatever transition was due this cycle
    if (restart) begin
      st_n     = RESET_PULSE;
      retry_n  = 4'd0;
      relink_n = relink_q;
    end

    if (st_n != st_q || restart) begin
      case (st_n)
        RESET_PULSE: tmr_n = 24'(RST_CYCLES - 1);
        WAIT_LOCK:   tmr_n = 24'(LOCK_TIMEOUT - 1);
        WAIT_DONE:   tmr_n = 24'(DONE_TIMEOUT - 1);
        WAIT_AN:     tmr_n = 24'(AN_TIMEOUT - 1);
        default:     tmr_n = 24'd0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q       <= RESET_PULSE;
      tmr_q      <= 24'(RST_CYCLES - 1);
      retry_q    <= '0;
      relink_q   <= '0;
      run_q      <= '0;
      buferr_q   <= '0;
      err_d      <= 1'b0;
      soft_reset <= 1'b1;
      link_up    <= 1'b0;
      fault      <= 1'b0;
    end else begin
      st_q       <= st_n;
      tmr_q      <= tmr_n;
      retry_q    <= retry_n;
      relink_q   <= relink_n;
      run_q      <= run_n;
      err_d      <= err_s;
      if (err_s && !err_d && buferr_q != 16'hFFFF) buferr_q <= buferr_q + 16'd1;
      soft_reset <= (st_n == RESET_PULSE) || (st_n == FAULT);
      link_up    <= (st_n == LINK_UP);
      fault      <= (st_n == FAULT);
    end
  end

  assign state      = st_q;
  assign retry_cnt  = retry_q;
  assign relink_cnt = relink_q;
  assign buferr_cnt = buferr_q;

endmodule
